// File: rtl/display_modn_count_if.sv
// Control inputs and display outputs of one modulo-N BCD display counter.
// The driving side uses master, the counter uses slave.
interface display_modn_count_if #(
   parameter int DIGITS = 2
);
   logic                  clear;
   logic                  count;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_bcd;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   ssl;
   logic                  carry;

   modport master (
      output clear, count, up, load, load_bcd,
      input  bcd, ssl, carry
   );

   modport slave (
      input  clear, count, up, load, load_bcd,
      output bcd, ssl, carry
   );
endinterface

// File: rtl/display_modn_count.sv
// Modulo-N BCD up/down counter with load, 7-segment decode, leading-zero blanking
// and a combinational carry/borrow that feeds the count input of the next stage.
module display_modn_count #(
   parameter int MODULO        = 60,
   parameter int DIGITS        = 2,
   parameter int BLANK_LEADING = 0
) (
   input logic                 clock,
   input logic                 reset,
   display_modn_count_if.slave bus
);
   localparam int W = 4*DIGITS;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / (10**k)) % 10);
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MODULO - 1);

   generate
      if (DIGITS < 1 || DIGITS > 4 || MODULO < 2 || MODULO > 10**DIGITS) begin : g_bad_param
         $error("display_modn_count: illegal MODULO/DIGITS combination");
      end
   endgenerate

   logic [W-1:0] val, inc, dec, nxt;
   logic         ci, bi, ld_ok, at_max, at_zero;

   // Ripple increment/decrement digit by digit; also qualify the load value.
   always_comb begin
      inc   = val;
      dec   = val;
      ci    = 1'b1;
      bi    = 1'b1;
      ld_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (ci) begin
            if (val[4*k +: 4] == 4'd9) inc[4*k +: 4] = 4'd0;
            else begin
               inc[4*k +: 4] = val[4*k +: 4] + 4'd1;
               ci = 1'b0;
            end
         end
         if (bi) begin
            if (val[4*k +: 4] == 4'd0) dec[4*k +: 4] = 4'd9;
            else begin
               dec[4*k +: 4] = val[4*k +: 4] - 4'd1;
               bi = 1'b0;
            end
         end
         if (bus.load_bcd[4*k +: 4] > 4'd9) ld_ok = 1'b0;
      end
      // With all digits legal, BCD order equals numeric order.
      if (bus.load_bcd > MAX_BCD) ld_ok = 1'b0;
   end

   assign at_max  = (val == MAX_BCD);
   assign at_zero = (val == '0);

   always_comb begin
      nxt = val;
      if (bus.up) nxt = at_max  ? '0      : inc;
      else        nxt = at_zero ? MAX_BCD : dec;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         val <= '0;
      else if (bus.clear) val <= '0;
      else if (bus.load)  val <= ld_ok ? bus.load_bcd : '0;
      else if (bus.count) val <= nxt;
   end

   assign bus.bcd   = val;
   assign bus.carry = reset & bus.count & ~bus.clear & ~bus.load & (bus.up ? at_max : at_zero);

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_seg
         if (g == 0) begin : g_lsd
            assign bus.ssl[6:0] = seg7(val[3:0]);
         end else begin : g_upper
            // Blank only when this digit and everything above it is zero.
            assign bus.ssl[7*g +: 7] = (BLANK_LEADING != 0 && val[W-1:4*g] == '0)
                                       ? 7'b0000000 : seg7(val[4*g +: 4]);
         end
      end
   endgenerate
endmodule
